// File: rtl/idli_pkg.sv
// idli_pkg: shared widths, slice counter type and control-state encoding for the idli core.
package idli_pkg;
   localparam int SLICE_W    = 4;
   localparam int NUM_SLICES = 16 / SLICE_W;
   localparam int CTR_W      = $clog2(NUM_SLICES);
   typedef logic [CTR_W-1:0] ctr_t;
   typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3} ctl_state_e;
endpackage

// File: rtl/idli_rst_sync_m.sv
// idli_rst_sync_m: reset synchroniser, asserts asynchronously and releases after STAGES edges.
module idli_rst_sync_m #(
   parameter int STAGES = 2
) (
   input  logic gck,
   input  logic arst_n,
   output logic rst_n
);
   import idli_pkg::*;
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge gck or negedge arst_n)
      if (!arst_n) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], 1'b1};
   assign rst_n = sync_q[STAGES-1];
endmodule

// File: rtl/idli_sync_ctl_m.sv
// idli_sync_ctl_m: reset sync, slice counter, word-aligned run/halt/step control and word counter.
module idli_sync_ctl_m #(
   parameter int DATA_W          = 16,
   parameter int SLICE_W         = 4,
   parameter int RST_SYNC_STAGES = 2,
   parameter int STARTUP_WORDS   = 8,
   localparam int NUM_SLICES     = DATA_W / SLICE_W,
   localparam int CTR_W          = $clog2(NUM_SLICES)
) (
   input  logic              i_top_gck,
   input  logic              i_top_rst_n,
   output logic              o_ctl_rst_n,
   output logic [CTR_W-1:0]  o_ctl_ctr,
   output logic              o_ctl_first,
   output logic              o_ctl_last,
   input  logic              i_ctl_halt_req,
   input  logic              i_ctl_step_req,
   output logic              o_ctl_run,
   output logic              o_ctl_halted,
   output logic [1:0]        o_ctl_state,
   output logic [DATA_W-1:0] o_ctl_word_cnt
);
   import idli_pkg::*;
   localparam int SU_W = $clog2(STARTUP_WORDS + 1) > 0 ? $clog2(STARTUP_WORDS + 1) : 1;

   if (NUM_SLICES < 2 || (NUM_SLICES & (NUM_SLICES - 1)) != 0 || NUM_SLICES * SLICE_W != DATA_W)
      begin : g_bad_slices
         $error("DATA_W/SLICE_W must be a power of two and at least 2");
      end
   if (RST_SYNC_STAGES < 2) begin : g_bad_stages
      $error("RST_SYNC_STAGES must be at least 2");
   end

   logic              rst_n;
   ctl_state_e        state_q, state_d;
   logic [CTR_W-1:0]  ctr_q;
   logic [DATA_W-1:0] wc_q;
   logic [SU_W-1:0]   su_q;
   logic              pend_q, pend_d, su_done, enter_go;

   idli_rst_sync_m #(.STAGES(RST_SYNC_STAGES)) u_rst_sync (
      .gck    (i_top_gck),
      .arst_n (i_top_rst_n),
      .rst_n  (rst_n)
   );

   assign su_done = su_q == SU_W'(STARTUP_WORDS);

   always_comb begin
      state_d = state_q;
      if (o_ctl_last)
         case (state_q)
            INIT:    state_d = su_done ? (i_ctl_halt_req ? HALT : RUN) : INIT;
            RUN:     state_d = i_ctl_halt_req ? HALT : RUN;
            HALT:    state_d = !i_ctl_halt_req ? RUN : pend_q ? STEP : HALT;
            default: state_d = HALT;
         endcase
   end

   // A pulse landing on the edge that enters STEP or RUN is absorbed, never queued.
   assign enter_go = state_d != state_q && (state_d == RUN || state_d == STEP);
   assign pend_d   = enter_go ? 1'b0 : (i_ctl_step_req && state_q != STEP) ? 1'b1 : pend_q;

   always_ff @(posedge i_top_gck or negedge rst_n)
      if (!rst_n) begin
         ctr_q   <= '0;
         state_q <= INIT;
         pend_q  <= 1'b0;
         su_q    <= '0;
         wc_q    <= '0;
      end else begin
         ctr_q   <= ctr_q + CTR_W'(1);
         state_q <= state_d;
         pend_q  <= pend_d;
         if (o_ctl_last && state_q == INIT && !su_done) su_q <= su_q + SU_W'(1);
         if (o_ctl_last && o_ctl_run) wc_q <= wc_q + DATA_W'(1);
      end

   assign o_ctl_rst_n    = rst_n;
   assign o_ctl_ctr      = ctr_q;
   assign o_ctl_first    = ctr_q == '0;
   assign o_ctl_last     = ctr_q == CTR_W'(NUM_SLICES - 1);
   assign o_ctl_run      = state_q == RUN || state_q == STEP;
   assign o_ctl_halted   = state_q == HALT;
   assign o_ctl_state    = state_q;
   assign o_ctl_word_cnt = wc_q;
endmodule

// File: tb/tb_idli_sync_ctl_m.sv
// tb_idli_sync_ctl_m: randomized and directed bench against an integer word-level model.
module tb_idli_sync_ctl_m;
   localparam int NS = 4, STAGES = 2, SW = 2;

   logic gck = 1'b0, rst_n = 1'b0, halt = 1'b0, step = 1'b0;
   always #5 gck = ~gck;

   logic        d_rst_n, d_first, d_last, d_run, d_halted;
   logic [1:0]  d_ctr, d_state;
   logic [15:0] d_wc;
   logic        e_rst_n, e_first, e_last, e_run, e_halted;
   logic [1:0]  e_ctr, e_state;
   logic [7:0]  e_wc;

   idli_sync_ctl_m #(.DATA_W(16), .SLICE_W(4), .RST_SYNC_STAGES(STAGES), .STARTUP_WORDS(SW)) dut (
      .i_top_gck(gck), .i_top_rst_n(rst_n), .o_ctl_rst_n(d_rst_n), .o_ctl_ctr(d_ctr),
      .o_ctl_first(d_first), .o_ctl_last(d_last), .i_ctl_halt_req(halt), .i_ctl_step_req(step),
      .o_ctl_run(d_run), .o_ctl_halted(d_halted), .o_ctl_state(d_state), .o_ctl_word_cnt(d_wc));

   idli_sync_ctl_m #(.DATA_W(8), .SLICE_W(2), .RST_SYNC_STAGES(2), .STARTUP_WORDS(0)) dut8 (
      .i_top_gck(gck), .i_top_rst_n(rst_n), .o_ctl_rst_n(e_rst_n), .o_ctl_ctr(e_ctr),
      .o_ctl_first(e_first), .o_ctl_last(e_last), .i_ctl_halt_req(1'b0), .i_ctl_step_req(1'b0),
      .o_ctl_run(e_run), .o_ctl_halted(e_halted), .o_ctl_state(e_state), .o_ctl_word_cnt(e_wc));

   int errs = 0, checks = 0;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: m_cyc counts edges since reset release; states 0..3 = INIT/RUN/HALT/STEP.
   int m_sync = 0, m_cyc = 0, m_state = 0, m_su = 0, m_wc = 0;
   bit m_rst_n = 1'b0, m_pend = 1'b0;
   always @(posedge gck or negedge rst_n) begin : mdl
      int nxt;
      if (!rst_n) begin
         m_sync <= 0; m_rst_n <= 1'b0; m_cyc <= 0; m_state <= 0; m_pend <= 1'b0; m_su <= 0; m_wc <= 0;
      end else if (!m_rst_n) begin
         m_sync  <= m_sync + 1;
         m_rst_n <= (m_sync + 1 >= STAGES);
      end else begin
         nxt = m_state;
         if (m_cyc % NS == NS - 1) begin
            if (m_state == 1 || m_state == 3) m_wc <= (m_wc + 1) % 65536;
            case (m_state)
               0: begin
                  nxt = (m_su == SW) ? (halt ? 2 : 1) : 0;
                  if (m_su != SW) m_su <= m_su + 1;
               end
               1: nxt = halt ? 2 : 1;
               2: nxt = !halt ? 1 : (m_pend ? 3 : 2);
               default: nxt = 2;
            endcase
         end
         if (nxt != m_state && (nxt == 1 || nxt == 3)) m_pend <= 1'b0;
         else if (step && m_state != 3) m_pend <= 1'b1;
         m_state <= nxt;
         m_cyc   <= m_cyc + 1;
      end
   end

   always @(negedge gck) begin
      chk("rst_n", int'(d_rst_n), int'(m_rst_n));
      chk("ctr", int'(d_ctr), m_cyc % NS);
      chk("first", int'(d_first), int'(m_cyc % NS == 0));
      chk("last", int'(d_last), int'(m_cyc % NS == NS - 1));
      chk("run", int'(d_run), int'(m_state == 1 || m_state == 3));
      chk("halted", int'(d_halted), int'(m_state == 2));
      chk("state", int'(d_state), m_state);
      chk("word_cnt", int'(d_wc), m_wc);
      chk("w8 rst_n", int'(e_rst_n), int'(m_rst_n));
      chk("w8 ctr", int'(e_ctr), m_cyc % 4);
      chk("w8 first", int'(e_first), int'(m_cyc % 4 == 0));
      chk("w8 last", int'(e_last), int'(m_cyc % 4 == 3));
      chk("w8 state", int'(e_state), int'(m_cyc >= 4));
      chk("w8 run", int'(e_run), int'(m_cyc >= 4));
      chk("w8 halted", int'(e_halted), 0);
      chk("w8 word_cnt", int'(e_wc), m_cyc >= 8 ? (m_cyc / 4 - 1) % 256 : 0);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge gck);
      #1;
   endtask

   task automatic to_ctr(input int v);
      int k = 0;
      do begin tick(1); k++; end while (m_cyc % NS != v && k < 16);
      if (m_cyc % NS != v) chk("to_ctr timeout", m_cyc % NS, v);
   endtask

   initial begin
      int guard = 0;
      tick(3);
      chk("reset ctr", int'(d_ctr), 0);
      chk("reset first", int'(d_first), 1);
      chk("reset state", int'(d_state), 0);
      chk("reset rst_n", int'(d_rst_n), 0);
      rst_n = 1'b1;
      tick(1); chk("sync edge1", int'(d_rst_n), 0);
      tick(1); chk("sync edge2", int'(d_rst_n), 1);
      chk("release ctr", int'(d_ctr), 0);
      tick(11); chk("init hold", int'(d_state), 0);
      chk("init ctr3", int'(d_ctr), 3);
      tick(1); chk("enter run", int'(d_state), 1);
      chk("enter run run", int'(d_run), 1);
      chk("enter run ctr", int'(d_ctr), 0);
      to_ctr(1); halt = 1'b1;
      tick(2); chk("halt wait run", int'(d_run), 1);
      tick(1); chk("halt halted", int'(d_halted), 1);
      chk("halt ctr", int'(d_ctr), 0);
      chk("halt wc", int'(d_wc), 1);
      tick(1); chk("halt counting", int'(d_ctr), 1);
      to_ctr(2); step = 1'b1;
      tick(1); step = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1); chk("step state", int'(d_state), 3);
         chk("step run", int'(d_run), 1);
      end
      tick(1); chk("step back", int'(d_state), 2);
      chk("step wc", int'(d_wc), 2);
      to_ctr(1); step = 1'b1; halt = 1'b0;
      tick(1); step = 1'b0;
      tick(2); chk("collide run", int'(d_state), 1);
      to_ctr(1); halt = 1'b1;
      tick(3); chk("rehalt", int'(d_state), 2);
      tick(4); chk("no spurious step", int'(d_state), 2);
      chk("no spurious run", int'(d_run), 0);
      while (m_cyc < 1100 && guard < 3000) begin
         tick(1); guard++;
         if (m_cyc == 1027) chk("w8 wrap 255", int'(e_wc), 255);
         if (m_cyc == 1028) chk("w8 wrap 0", int'(e_wc), 0);
         if ($urandom_range(15) == 0) halt = ~halt;
         step = ($urandom_range(7) == 0);
      end
      step = 1'b0; halt = 1'b0; rst_n = 1'b0;
      tick(2); rst_n = 1'b1;
      tick(2);
      tick(34);
      chk("pre-reset ctr", int'(d_ctr), 2);
      chk("pre-reset state", int'(d_state), 1);
      chk("pre-reset wc", int'(d_wc), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst_n", int'(d_rst_n), 0);
      chk("async ctr", int'(d_ctr), 0);
      chk("async run", int'(d_run), 0);
      chk("async wc", int'(d_wc), 0);
      chk("async state", int'(d_state), 0);
      chk("async first", int'(d_first), 1);
      chk("async last", int'(d_last), 0);
      tick(2);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
